// File: rtl/cartoon_pkg.sv
// Shared types and constants for the cartoon filter pixel fetch path.
// Holds the FSM state enum and the 3x3 window index helpers.
package cartoon_pkg;

  localparam int PIXEL_W = 24;
  localparam int WIN_W   = 216;

  localparam logic [3:0] LOAD_LAST_IDX  = 4'd8;
  localparam logic [3:0] SHIFT_LAST_IDX = 4'd2;
  localparam logic [1:0] LAST_COL       = 2'd2;
  localparam logic [1:0] CENTRE_OFS     = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD9,
    ST_PRESENT,
    ST_SHIFT3,
    ST_DONE
  } fetch_state_t;

  // Row (dy) of the k-th read of a full 9-pixel load, rows outer.
  function automatic logic [1:0] load_dy(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: load_dy = 2'd0;
      4'd3, 4'd4, 4'd5: load_dy = 2'd1;
      default:          load_dy = 2'd2;
    endcase
  endfunction

  // Column (dx) of the k-th read of a full 9-pixel load, columns inner.
  function automatic logic [1:0] load_dx(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: load_dx = 2'd0;
      4'd1, 4'd4, 4'd7: load_dx = 2'd1;
      default:          load_dx = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Maps a window position (cy,dy,cx,dx) to a 32-bit byte address:
// base + 4*((cy-1+dy)*width + (cx-1+dx)), wrapping modulo 2^32.
module fetch_addr_gen #(
  parameter int DIM_W = 10
) (
  input  logic [31:0]      base,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] cy,
  input  logic [DIM_W-1:0] cx,
  input  logic [1:0]       dy,
  input  logic [1:0]       dx,
  output logic [31:0]      addr
);

  logic [31:0] row;
  logic [31:0] col;
  logic [31:0] lin;

  always_comb begin
    row  = 32'(cy) + 32'(dy) - 32'd1;
    col  = 32'(cx) + 32'(dx) - 32'd1;
    lin  = row * 32'(width) + col;
    addr = base + (lin << 2);
  end

endmodule

// File: rtl/pixel_fetch.sv
// Fetches 3x3 pixel windows in raster order over an Avalon-MM read master,
// reloading all nine pixels at each row start and three per step otherwise.
module pixel_fetch
  import cartoon_pkg::*;
#(
  parameter int DIM_W = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [31:0]       src_base,
  input  logic [31:0]       dst_base,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic              master_waitrequest,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic [WIN_W-1:0]  pixelData,
  output logic              window_valid,
  input  logic              window_ready,
  output logic [31:0]       out_addr,
  output logic              frame_done
);

  fetch_state_t state, next_state;

  logic [31:0]      src_q, dst_q;
  logic [DIM_W-1:0] w_q, h_q;
  logic [DIM_W-1:0] cx, cy;
  logic [3:0]       rd_idx;
  logic             pending;

  logic             rd_done, burst_end, row_end, last_row, small_img;
  logic [3:0]       last_idx, iss_idx, cap_slot;
  logic [1:0]       iss_dy, iss_dx;
  logic [31:0]      rd_addr, ctr_addr;
  logic             unused_hi;

  assign unused_hi = ^master_readdata[31:PIXEL_W];

  always_comb begin
    rd_done   = pending && master_readdatavalid;
    last_idx  = (state == ST_SHIFT3) ? SHIFT_LAST_IDX : LOAD_LAST_IDX;
    burst_end = rd_done && (rd_idx == last_idx);
    row_end   = (cx == w_q - DIM_W'(2));
    last_row  = (cy == h_q - DIM_W'(2));
    small_img = (img_width < DIM_W'(3)) || (img_height < DIM_W'(3));
    // While a word is pending, the next issue (on its capture) targets rd_idx+1.
    iss_idx   = pending ? rd_idx + 4'd1 : rd_idx;
    if (state == ST_SHIFT3) begin
      iss_dy   = iss_idx[1:0];
      iss_dx   = LAST_COL;
      cap_slot = 4'(rd_idx * 4'd3 + 4'd2);
    end else begin
      iss_dy   = load_dy(iss_idx);
      iss_dx   = load_dx(iss_idx);
      cap_slot = rd_idx;
    end
  end

  fetch_addr_gen #(.DIM_W(DIM_W)) u_rd_addr (
    .base  (src_q),
    .width (w_q),
    .cy    (cy),
    .cx    (cx),
    .dy    (iss_dy),
    .dx    (iss_dx),
    .addr  (rd_addr)
  );

  fetch_addr_gen #(.DIM_W(DIM_W)) u_ctr_addr (
    .base  (dst_q),
    .width (w_q),
    .cy    (cy),
    .cx    (cx),
    .dy    (CENTRE_OFS),
    .dx    (CENTRE_OFS),
    .addr  (ctr_addr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = small_img ? ST_DONE : ST_LOAD9;
      ST_LOAD9,
      ST_SHIFT3:  if (burst_end) next_state = ST_PRESENT;
      ST_PRESENT: if (window_ready) begin
                    if (!row_end)      next_state = ST_SHIFT3;
                    else if (!last_row) next_state = ST_LOAD9;
                    else               next_state = ST_DONE;
                  end
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      src_q          <= '0;
      dst_q          <= '0;
      w_q            <= '0;
      h_q            <= '0;
      cx             <= '0;
      cy             <= '0;
      rd_idx         <= '0;
      pending        <= 1'b0;
      master_read    <= 1'b0;
      master_address <= '0;
      pixelData      <= '0;
      window_valid   <= 1'b0;
      out_addr       <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= (next_state == ST_DONE);
      case (state)
        ST_IDLE: if (start) begin
          src_q       <= src_base;
          dst_q       <= dst_base;
          w_q         <= img_width;
          h_q         <= img_height;
          cx          <= DIM_W'(1);
          cy          <= DIM_W'(1);
          rd_idx      <= '0;
          pending     <= 1'b0;
          master_read <= 1'b0;
        end
        ST_LOAD9, ST_SHIFT3: begin
          if (rd_done) begin
            pending <= 1'b0;
            pixelData[int'(cap_slot)*PIXEL_W +: PIXEL_W] <= master_readdata[PIXEL_W-1:0];
            if (burst_end) begin
              window_valid <= 1'b1;
              out_addr     <= ctr_addr;
            end else begin
              rd_idx         <= rd_idx + 4'd1;
              master_read    <= 1'b1;
              master_address <= rd_addr;
            end
          end else if (master_read && !master_waitrequest) begin
            master_read <= 1'b0;
            pending     <= 1'b1;
          end else if (!master_read && !pending) begin
            master_read    <= 1'b1;
            master_address <= rd_addr;
          end
        end
        ST_PRESENT: if (window_ready) begin
          window_valid <= 1'b0;
          rd_idx       <= '0;
          if (!row_end) begin
            cx <= cx + DIM_W'(1);
            // Slide the window one column left; column 2 is refilled by SHIFT3.
            for (int dy = 0; dy < 3; dy++) begin
              pixelData[(3*dy)*PIXEL_W +: PIXEL_W]   <= pixelData[(3*dy+1)*PIXEL_W +: PIXEL_W];
              pixelData[(3*dy+1)*PIXEL_W +: PIXEL_W] <= pixelData[(3*dy+2)*PIXEL_W +: PIXEL_W];
            end
          end else if (!last_row) begin
            cx <= DIM_W'(1);
            cy <= cy + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: table of frames plus hand-written
// sequences for stalls, held windows, tiny images and mid-frame reset.
module tb_pixel_fetch;

  localparam int DIM = 10;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic [31:0]      src_base, dst_base;
  logic [DIM-1:0]   img_width, img_height;
  logic [31:0]      master_address;
  logic             master_read;
  logic             master_waitrequest;
  logic [31:0]      master_readdata;
  logic             master_readdatavalid;
  logic [215:0]     pixelData;
  logic             window_valid;
  logic             window_ready;
  logic [31:0]      out_addr;
  logic             frame_done;

  pixel_fetch #(.DIM_W(DIM)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .start                (start),
    .src_base             (src_base),
    .dst_base             (dst_base),
    .img_width            (img_width),
    .img_height           (img_height),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .pixelData            (pixelData),
    .window_valid         (window_valid),
    .window_ready         (window_ready),
    .out_addr             (out_addr),
    .frame_done           (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input logic [31:0] a);
    return {8'hA5, a[23:0] ^ 24'h3C5A96};
  endfunction

  // Slave model: optional stall on one read, data one cycle after acceptance.
  logic [31:0] rd_log[$];
  int          rdv_cnt, mr_high, stall_no, stall_cycles, stall_done;
  logic [31:0] stall_addr, acc_addr;
  logic        acc_pend = 1'b0;
  logic        force_rdv = 1'b0;

  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = 32'h0;
    if (acc_pend) begin
      master_readdatavalid = 1'b1;
      master_readdata      = pix(acc_addr);
      acc_pend             = 1'b0;
      rdv_cnt++;
    end else if (force_rdv) begin
      master_readdatavalid = 1'b1;
      master_readdata      = 32'hDEADBEEF;
    end
    master_waitrequest = 1'b0;
    if (master_read) begin
      mr_high++;
      if (rd_log.size() + 1 == stall_no && stall_done < stall_cycles) begin
        master_waitrequest = 1'b1;
        if (stall_done == 0) stall_addr = master_address;
        else chk("stall_addr_stable", master_address, stall_addr);
        stall_done++;
      end else begin
        if (stall_done > 0 && rd_log.size() + 1 == stall_no)
          chk("stall_addr_at_accept", master_address, stall_addr);
        rd_log.push_back(master_address);
        acc_pend = 1'b1;
        acc_addr = master_address;
      end
    end
  end

  logic [215:0] win_pix[$];
  logic [31:0]  win_out[$];
  int           n_done, done_cyc;

  task automatic run_frame(input int w, input int h, input logic [31:0] src,
                           input logic [31:0] dst, input int hold);
    int cyc;
    bit finished;
    logic [215:0] saved;
    rd_log.delete(); win_pix.delete(); win_out.delete();
    rdv_cnt = 0; mr_high = 0; stall_done = 0; n_done = 0; done_cyc = -1;
    @(negedge clk);
    src_base = src; dst_base = dst;
    img_width = DIM'(w); img_height = DIM'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; finished = 0;
    while (!finished && cyc < 4000) begin
      if (frame_done) begin n_done++; finished = 1; done_cyc = cyc; end
      if (window_valid && !window_ready) begin
        win_pix.push_back(pixelData);
        win_out.push_back(out_addr);
        if (hold > 0 && win_pix.size() == 1) begin
          saved = pixelData;
          for (int i = 0; i < hold; i++) begin
            @(negedge clk); cyc++;
            chk("hold_valid", window_valid, 1'b1);
            chk("hold_pixels", pixelData, saved);
            chk("hold_no_read", master_read, 1'b0);
          end
        end
        window_ready = 1'b1;
      end else begin
        window_ready = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    window_ready = 1'b0;
    if (!finished) begin
      errors++; checks++;
      $display("FAIL frame_timeout: got no frame_done expected frame_done within 4000 cycles");
    end
    chk("frame_done_single", frame_done, 1'b0);
  endtask

  function automatic logic [215:0] exp_win(input int w, input logic [31:0] src, input int j);
    int cx, cy;
    logic [31:0] a, p;
    logic [215:0] r;
    cx = 1 + j % (w - 2);
    cy = 1 + j / (w - 2);
    r = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        a = src + 32'(4 * ((cy - 1 + dy) * w + (cx - 1 + dx)));
        p = pix(a);
        r[(3*dy+dx)*24 +: 24] = p[23:0];
      end
    return r;
  endfunction

  typedef struct {
    int          w, h;
    logic [31:0] src, dst;
    int          reads, wins;
    logic [31:0] last_rd, first_out, last_out;
  } vec_t;

  vec_t vecs[7];

  task automatic check_frame(input vec_t v);
    chk("read_count", rd_log.size(), v.reads);
    chk("rdv_count", rdv_cnt, v.reads);
    chk("window_count", win_pix.size(), v.wins);
    chk("frame_done_count", n_done, 1);
    for (int j = 0; j < win_pix.size(); j++) begin
      chk("window_pixels", win_pix[j], exp_win(v.w, v.src, j));
    end
    if (v.wins > 0 && win_out.size() > 0) begin
      chk("first_out_addr", win_out[0], v.first_out);
      chk("last_out_addr", win_out[win_out.size()-1], v.last_out);
    end
    if (v.reads > 0 && rd_log.size() > 0)
      chk("last_read_addr", rd_log[rd_log.size()-1], v.last_rd);
  endtask

  initial begin
    logic [23:0] a0, b0;
    int cyc;
    vecs[0] = '{3, 3, 32'h1000,     32'h2000,     9,  1, 32'h1020, 32'h2010, 32'h2010};
    vecs[1] = '{4, 3, 32'h0,        32'h100,      12, 2, 32'h2C,   32'h114,  32'h118};
    vecs[2] = '{3, 4, 32'h40,       32'h0,        18, 2, 32'h6C,   32'h10,   32'h1C};
    vecs[3] = '{5, 4, 32'h100,      32'h800,      30, 6, 32'h14C,  32'h818,  32'h834};
    vecs[4] = '{3, 3, 32'hFFFFFFF0, 32'hFFFFFFF8, 9,  1, 32'h10,   32'h8,    32'h8};
    vecs[5] = '{2, 5, 32'h500,      32'h0,        0,  0, 32'h0,    32'h0,    32'h0};
    vecs[6] = '{5, 2, 32'h500,      32'h0,        0,  0, 32'h0,    32'h0,    32'h0};

    n_rst = 1'b0; start = 1'b0; window_ready = 1'b0;
    src_base = '0; dst_base = '0; img_width = '0; img_height = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    stall_no = 0; stall_cycles = 0; stall_done = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_master_read", master_read, 1'b0);
    chk("rst_master_address", master_address, 32'h0);
    chk("rst_pixelData", pixelData, 216'h0);
    chk("rst_window_valid", window_valid, 1'b0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    n_rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].src, vecs[i].dst, 0);
      check_frame(vecs[i]);
      if (vecs[i].reads == 0) begin
        chk("small_done_latency_le3", done_cyc <= 3, 1'b1);
        chk("small_no_read", mr_high, 0);
      end
    end

    // 3x3: read addresses strictly in raster order
    run_frame(3, 3, 32'h1000, 32'h2000, 0);
    chk("seq3x3_count", rd_log.size(), 9);
    for (int i = 0; i < 9 && i < rd_log.size(); i++)
      chk("seq3x3_addr", rd_log[i], 32'h1000 + 32'(4*i));

    // 4x3: shift step reads column 3 and keeps the old column 1 as column 0
    run_frame(4, 3, 32'h0, 32'h100, 0);
    if (rd_log.size() == 12 && win_pix.size() == 2) begin
      chk("shift_rd0", rd_log[9],  32'h0C);
      chk("shift_rd1", rd_log[10], 32'h1C);
      chk("shift_rd2", rd_log[11], 32'h2C);
      for (int dy = 0; dy < 3; dy++) begin
        a0 = win_pix[1][(3*dy)*24 +: 24];
        b0 = win_pix[0][(3*dy+1)*24 +: 24];
        chk("shift_col0_eq_col1", a0, b0);
      end
    end else begin
      chk("shift_shape", {rd_log.size(), win_pix.size()}, {32'd12, 32'd2});
    end

    // waitrequest held for 3 cycles on the 2nd read
    stall_no = 2; stall_cycles = 3;
    run_frame(3, 3, 32'h1000, 32'h2000, 0);
    chk("stall_cycles_seen", stall_done, 3);
    check_frame(vecs[0]);
    stall_no = 0; stall_cycles = 0;

    // window_ready held low for 20 cycles on the first window
    run_frame(4, 3, 32'h0, 32'h100, 20);
    check_frame(vecs[1]);

    // reset while the 5th LOAD9 read is outstanding
    rd_log.delete();
    @(negedge clk);
    src_base = 32'h3000; dst_base = 32'h4000; img_width = 3; img_height = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rd_log.size() < 5 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    chk("rst_reached_5th_read", rd_log.size(), 5);
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_master_read", master_read, 1'b0);
    chk("midrst_master_address", master_address, 32'h0);
    chk("midrst_pixelData", pixelData, 216'h0);
    chk("midrst_window_valid", window_valid, 1'b0);
    chk("midrst_out_addr", out_addr, 32'h0);
    chk("midrst_frame_done", frame_done, 1'b0);
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    #1 force_rdv = 1'b1;
    @(negedge clk);
    #1 force_rdv = 1'b0;
    @(negedge clk);
    chk("late_rdv_no_read", master_read, 1'b0);
    chk("late_rdv_no_window", window_valid, 1'b0);
    run_frame(3, 3, 32'h3000, 32'h4000, 0);
    chk("restart_count", rd_log.size(), 9);
    if (rd_log.size() > 0) chk("restart_first_addr", rd_log[0], 32'h3000);
    chk("restart_windows", win_pix.size(), 1);
    if (win_pix.size() > 0) begin
      chk("restart_pixels", win_pix[0], exp_win(3, 32'h3000, 0));
      chk("restart_out_addr", win_out[0], 32'h4010);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
